nios2_keys_debounced: RTL

//  Avalon-MM PIO slave for pushbutton/switch inputs: a parametrised successor of the 4-bit KEY PIO.
//  Per channel: 2-FF synchroniser, counter debounce, selectable edge type, IRQ mask, edge-capture register.

---
 rtl/nios2_keys_debounced.sv | 129 ++++++++++++
 1 files changed

// File: rtl/nios2_keys_debounced.sv
// Avalon-MM PIO slave for debounced key/switch inputs with edge capture and IRQ.
module nios2_keys_debounced #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] wr_clr;
  logic [WIDTH-1:0] rd_mux;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic             wr_en;
  logic             unused_wd;

  assign wr_en = chipselect & ~write_n;

  // Only writedata[WIDTH-1:0] carries register content; upper bits are ignored.
  assign unused_wd = ^writedata;

  // Two-flop synchroniser, reset to the idle level so no edge appears after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= {WIDTH{IDLE_LEVEL}};
      s2 <= {WIDTH{IDLE_LEVEL}};
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // Acceptance strobe and qualified edge event per channel.
  always_comb begin
    upd = '0;
    ev  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      upd[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
      case (EDGE_TYPE)
        0:       ev[i] = upd[i] & s2[i];
        1:       ev[i] = upd[i] & ~s2[i];
        default: ev[i] = upd[i];
      endcase
    end
  end

  // Counter debounce: a new level must persist DEBOUNCE_CYCLES clocks to be accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= {WIDTH{IDLE_LEVEL}};
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Write-1-to-clear mask for the capture register.
  always_comb begin
    wr_clr = '0;
    if (wr_en && (address == 2'd3)) begin
      wr_clr = writedata[WIDTH-1:0];
    end
  end

  // IRQ mask and edge capture; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && (address == 2'd2)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_capture <= (edge_capture & ~wr_clr) | ev;
    end
  end

  // Read source selection.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = stable;
      2'd1:    rd_mux = s2;
      2'd2:    rd_mux = irq_mask;
      default: rd_mux = edge_capture;
    endcase
  end

  // Registered read data, one-cycle latency, zero-extended.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= 32'(rd_mux);
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
